// File: rtl/command_sequencer_if.sv
// Command receive FIFO and reply/control bundle between the FIFO side and the sequencer.
interface command_sequencer_if #(
    parameter int CNT_W = 5
);
    logic [CNT_W-1:0] com_count;
    logic [7:0]       rec_command;
    logic             com_pop;
    logic             force_swi;
    logic             com_swi;
    logic             reset_A;
    logic             reset_B;
    logic             error;
    logic             tf_push_cpuAB;
    logic [7:0]       tdr_cpuAB;

    // FIFO / environment side
    modport master (
        output com_count, rec_command,
        input  com_pop, force_swi, com_swi, reset_A, reset_B, error,
               tf_push_cpuAB, tdr_cpuAB
    );

    // Sequencer side
    modport slave (
        input  com_count, rec_command,
        output com_pop, force_swi, com_swi, reset_A, reset_B, error,
               tf_push_cpuAB, tdr_cpuAB
    );
endinterface

// File: rtl/command_sequencer.sv
// Command frame sequencer: pulls 8-byte frames from the receive FIFO, validates
// header/checksum/command, applies the command and pushes a 2-byte reply.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | wait for a full frame (>= 8 bytes) in the receive FIFO
// S_FETCH  | latch FIFO head into frame byte idx and pop it
// S_GAP    | no pop while FIFO head updates; header resync; advance idx
// S_CHECK  | verify checksum and command range
// S_EXEC   | apply command (switch mode / reset pulse timers)
// S_REPLY0 | push 0xAC
// S_REPLY1 | push echoed command byte
module command_sequencer #(
    parameter int CNT_W     = 5,
    parameter int RST_PULSE = 16,
    parameter int ERR_HOLD  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    command_sequencer_if.slave  bus
);

    localparam int RST_W = $clog2(RST_PULSE + 1);
    localparam int ERR_W = $clog2(ERR_HOLD + 1);
    localparam logic [RST_W-1:0] RST_LOAD    = RST_W'(RST_PULSE);
    localparam logic [ERR_W-1:0] ERR_LOAD    = ERR_W'(ERR_HOLD);
    localparam logic [CNT_W-1:0] FRAME_BYTES = CNT_W'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GAP,
        S_CHECK,
        S_EXEC,
        S_REPLY0,
        S_REPLY1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       frame_q [8];
    logic             force_q;
    logic             swi_q;
    logic [RST_W-1:0] rsta_q;
    logic [RST_W-1:0] rstb_q;
    logic [ERR_W-1:0] err_q;

    logic [CNT_W-1:0] count;
    logic [7:0]       sum;
    logic [7:0]       cmd;
    logic             cmd_ok;
    logic             pop;
    logic             latch;
    logic             err_load;
    logic             exec_en;
    logic             push;
    logic [7:0]       tdr;

    assign count  = bus.com_count;
    assign cmd    = frame_q[2];
    assign cmd_ok = (cmd >= 8'h01) && (cmd <= 8'h05);

    // State, byte index and frame buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) frame_q[idx_q] <= bus.rec_command;
        end
    end

    // Next-state decode, FIFO pop, reply push and timer load strobes
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        latch    = 1'b0;
        err_load = 1'b0;
        exec_en  = 1'b0;
        push     = 1'b0;
        tdr      = 8'h00;
        sum      = 8'h00;
        for (int i = 0; i < 7; i++) sum = sum + frame_q[i];

        case (state_q)
            S_IDLE: begin
                if (count >= FRAME_BYTES) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A drained FIFO only happens if the source misbehaves; never pop empty.
                if (count != '0) begin
                    pop     = 1'b1;
                    latch   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if ((idx_q == 3'd0 && frame_q[0] != 8'hEB) ||
                    (idx_q == 3'd1 && frame_q[1] != 8'h90)) begin
                    state_d = S_IDLE;
                end else if (idx_q == 3'd7) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_FETCH;
                end
            end
            S_CHECK: begin
                if (sum != frame_q[7] || !cmd_ok) begin
                    err_load = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                state_d = S_REPLY0;
            end
            S_REPLY0: begin
                push    = 1'b1;
                tdr     = 8'hAC;
                state_d = S_REPLY1;
            end
            S_REPLY1: begin
                push    = 1'b1;
                tdr     = cmd;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Commanded-switch mode registers, updated when a command executes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_q <= 1'b0;
            swi_q   <= 1'b0;
        end else if (exec_en) begin
            case (cmd)
                8'h01: begin force_q <= 1'b1; swi_q <= 1'b0; end
                8'h02: begin force_q <= 1'b1; swi_q <= 1'b1; end
                8'h05: force_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Reset-pulse and error down-counters; a load always restarts, otherwise count to 0 and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsta_q <= '0;
            rstb_q <= '0;
            err_q  <= '0;
        end else begin
            if (exec_en && cmd == 8'h03) rsta_q <= RST_LOAD;
            else if (rsta_q != '0)       rsta_q <= rsta_q - RST_W'(1);

            if (exec_en && cmd == 8'h04) rstb_q <= RST_LOAD;
            else if (rstb_q != '0)       rstb_q <= rstb_q - RST_W'(1);

            if (err_load)                err_q <= ERR_LOAD;
            else if (err_q != '0)        err_q <= err_q - ERR_W'(1);
        end
    end

    assign bus.com_pop       = pop;
    assign bus.force_swi     = force_q;
    assign bus.com_swi       = swi_q;
    assign bus.reset_A       = (rsta_q != '0);
    assign bus.reset_B       = (rstb_q != '0);
    assign bus.error         = (err_q != '0);
    assign bus.tf_push_cpuAB = push;
    assign bus.tdr_cpuAB     = tdr;

endmodule

// File: tb/tb_command_sequencer.sv
// Self-checking bench for command_sequencer: FIFO model, event monitor and frame-level reference.
module tb_command_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    command_sequencer_if #(.CNT_W(5)) bus ();

    command_sequencer #(.CNT_W(5), .RST_PULSE(16), .ERR_HOLD(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // FIFO model (written only by the stimulus process)
    logic [7:0] fifo_q [$];
    int         lim     = 31;
    int         applied = 0;

    // Monitor state (written only by the monitor process)
    int         cyc = 0, pops = 0, pop_viol = 0, pop_empty = 0;
    logic       prev_pop = 1'b0;
    logic [7:0] push_q [$];
    int         pop_cyc_q [$];
    int         push_cyc_q [$];
    int         ra_run = 0, ra_last = 0, rb_high = 0, err_run = 0, err_last = 0;

    // Observe DUT outputs mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (bus.com_pop === 1'b1) begin
            pops++;
            pop_cyc_q.push_back(cyc);
            if (prev_pop) pop_viol++;
            if (bus.com_count == 5'd0) pop_empty++;
        end
        prev_pop = (bus.com_pop === 1'b1);
        if (bus.tf_push_cpuAB === 1'b1) begin
            push_q.push_back(bus.tdr_cpuAB);
            push_cyc_q.push_back(cyc);
        end
        if (bus.reset_A === 1'b1) ra_run++;
        else if (ra_run > 0) begin ra_last = ra_run; ra_run = 0; end
        if (bus.reset_B === 1'b1) rb_high++;
        if (bus.error === 1'b1) err_run++;
        else if (err_run > 0) begin err_last = err_run; err_run = 0; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.com_count   = (fifo_q.size() < lim) ? 5'(fifo_q.size()) : 5'(lim);
        bus.rec_command = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // Advance one clock; retire bytes the DUT popped at that edge
    task automatic tick();
        @(posedge clk);
        #1;
        while (applied < pops) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            applied++;
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Queue one frame; checksum is the plain byte sum, optionally corrupted by xor
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] cks_xor);
        int s;
        s = (8'hEB + 8'h90 + cmd + arg + r0 + r1 + r2) % 256;
        fifo_q.push_back(8'hEB);
        fifo_q.push_back(8'h90);
        fifo_q.push_back(cmd);
        fifo_q.push_back(arg);
        fifo_q.push_back(r0);
        fifo_q.push_back(r1);
        fifo_q.push_back(r2);
        fifo_q.push_back(8'(s) ^ cks_xor);
        drive();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (fifo_q.size() != 0 && n < budget) begin tick(); n++; end
        check(tag, fifo_q.size(), 0);
        ticks(8);
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, bus.com_pop, bus.force_swi, bus.com_swi, bus.reset_A, bus.reset_B,
                bus.error, bus.tf_push_cpuAB, bus.tdr_cpuAB};
    endfunction

    initial begin
        int pb, qb, c0, n, ok;
        logic exp_force, exp_swi;

        rst_n = 1'b0;
        bus.com_count   = '0;
        bus.rec_command = '0;
        ticks(3);
        check("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        ticks(2);

        // Command 0x02: select CPU B
        pb = push_q.size(); qb = pops;
        send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_drain("f02_drain", 60);
        check("f02_pops", pops - qb, 8);
        ok = 1;
        if (pop_cyc_q.size() >= qb + 8) begin
            for (int i = 1; i < 8; i++)
                if (pop_cyc_q[qb + i] - pop_cyc_q[qb + i - 1] != 2) ok = 0;
        end else ok = 0;
        check("f02_pop_alternate", ok, 1);
        check("f02_push_count", push_q.size() - pb, 2);
        if (push_q.size() >= pb + 2) begin
            check("f02_reply0", push_q[pb], 8'hAC);
            check("f02_reply1", push_q[pb + 1], 8'h02);
            // first FETCH is cycle 1, first reply push is cycle 19
            check("f02_latency", push_cyc_q[pb] - pop_cyc_q[qb], 18);
        end
        check("f02_force", bus.force_swi, 1);
        check("f02_swi", bus.com_swi, 1);

        // Command 0x03: reset pulse on CPU A
        pb = push_q.size();
        send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_drain("f03_drain", 60);
        check("f03_resetA_active", bus.reset_A, 1);
        n = 0;
        while (bus.reset_A === 1'b1 && n < 40) begin tick(); n++; end
        tick();
        check("f03_resetA_len", ra_last, 16);
        check("f03_resetB_idle", rb_high, 0);
        check("f03_push_count", push_q.size() - pb, 2);
        if (push_q.size() >= pb + 2) begin
            check("f03_reply0", push_q[pb], 8'hAC);
            check("f03_reply1", push_q[pb + 1], 8'h03);
        end

        // Bad checksum: error, no reply, mode unchanged
        pb = push_q.size();
        send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7C);
        wait_drain("bad_drain", 60);
        check("bad_error_on", bus.error, 1);
        check("bad_no_push", push_q.size() - pb, 0);
        check("bad_force_kept", bus.force_swi, 1);
        n = 0;
        while (bus.error === 1'b1 && n < 1200) begin tick(); n++; end
        tick();
        check("bad_error_len", err_last, 1024);

        // Leading garbage byte then command 0x05
        pb = push_q.size(); qb = pops;
        fifo_q.push_back(8'h55);
        send_frame(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_drain("resync_drain", 80);
        check("resync_pops", pops - qb, 9);
        check("resync_no_error", bus.error, 0);
        check("resync_force", bus.force_swi, 0);
        check("resync_swi_kept", bus.com_swi, 1);
        check("resync_push_count", push_q.size() - pb, 2);
        if (push_q.size() >= pb + 2) check("resync_reply1", push_q[pb + 1], 8'h05);

        // Seven bytes visible: no start; eight: start next cycle
        lim = 7;
        qb = pops;
        send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        ticks(20);
        check("cnt7_no_pop", pops - qb, 0);
        lim = 31;
        drive();
        c0 = cyc;
        ticks(3);
        if (pop_cyc_q.size() > qb) check("cnt8_start", pop_cyc_q[qb], c0 + 2);
        else check("cnt8_start", pops - qb, 1);
        wait_drain("cnt8_drain", 60);
        exp_force = 1'b1;
        exp_swi   = 1'b0;
        check("cnt8_force", bus.force_swi, exp_force);
        check("cnt8_swi", bus.com_swi, exp_swi);

        // Randomized frames against the frame-level model
        for (int k = 0; k < 12; k++) begin
            logic [7:0] cmd, x, junk;
            logic valid;
            cmd = 8'($urandom_range(0, 7));
            x   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            valid = (x == 8'h00) && (cmd >= 8'h01) && (cmd <= 8'h05);
            pb = push_q.size();
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hEB) junk = 8'h55;
                fifo_q.push_back(junk);
            end
            send_frame(cmd, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), x);
            wait_drain("rnd_drain", 80);
            if (valid) begin
                if (cmd == 8'h01) begin exp_force = 1'b1; exp_swi = 1'b0; end
                if (cmd == 8'h02) begin exp_force = 1'b1; exp_swi = 1'b1; end
                if (cmd == 8'h05) exp_force = 1'b0;
                check("rnd_push_count", push_q.size() - pb, 2);
                if (push_q.size() >= pb + 2) begin
                    check("rnd_reply0", push_q[pb], 8'hAC);
                    check("rnd_reply1", push_q[pb + 1], cmd);
                end
                if (cmd == 8'h03) check("rnd_resetA", bus.reset_A, 1);
                if (cmd == 8'h04) check("rnd_resetB", bus.reset_B, 1);
            end else begin
                check("rnd_no_push", push_q.size() - pb, 0);
                check("rnd_error", bus.error, 1);
            end
            check("rnd_force", bus.force_swi, exp_force);
            check("rnd_swi", bus.com_swi, exp_swi);
        end

        // Reset after the fourth pop of a frame
        qb = pops;
        send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        n = 0;
        while (pops - qb < 4 && n < 40) begin tick(); n++; end
        check("mid_pops_before", pops - qb, 4);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs(), 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(20);
        check("mid_no_resume", pops - qb, 4);
        check("mid_left_bytes", fifo_q.size(), 4);
        pb = push_q.size();
        send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_drain("mid_drain", 120);
        check("mid_total_pops", pops - qb, 16);
        check("mid_push_count", push_q.size() - pb, 2);
        if (push_q.size() >= pb + 2) check("mid_reply1", push_q[pb + 1], 8'h01);
        check("mid_force", bus.force_swi, 1);
        check("mid_swi", bus.com_swi, 0);

        check("pop_never_back_to_back", pop_viol, 0);
        check("pop_never_empty", pop_empty, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 5, giving the width of the receive-FIFO byte count.
REQ-002 The block SHALL have parameter RST_PULSE, default 16, giving the CPU reset pulse length in clk cycles.
REQ-003 The block SHALL have parameter ERR_HOLD, default 1024, giving the error indication length in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port com_count, input, CNT_W bits: bytes held in the selected command receive FIFO.
REQ-007 The block SHALL have port rec_command, input, 8 bits: FIFO head byte, valid whenever com_count > 0.
REQ-008 The block SHALL have port com_pop, output, 1 bit: one-cycle pulse that removes the FIFO head byte.
REQ-009 The block SHALL have port force_swi, output, 1 bit: level, commanded-switch mode active.
REQ-010 The block SHALL have port com_swi, output, 1 bit: commanded target CPU, 0 = A, 1 = B.
REQ-011 The block SHALL have port reset_A, output, 1 bit: CPU A reset request, active high.
REQ-012 The block SHALL have port reset_B, output, 1 bit: CPU B reset request, active high.
REQ-013 The block SHALL have port error, output, 1 bit: frame error indication.
REQ-014 The block SHALL have port tf_push_cpuAB, output, 1 bit: one-cycle push strobe to both CPU transmit FIFOs.
REQ-015 The block SHALL have port tdr_cpuAB, output, 8 bits: reply byte, valid while tf_push_cpuAB = 1.

Function
REQ-016 Frame format SHALL be 8 bytes: B0=0xEB, B1=0x90, B2=cmd, B3=arg, B4..B6 reserved, B7 = (B0+...+B6) mod 256.
REQ-017 The FSM SHALL have states IDLE, FETCH, GAP, CHECK, EXEC, REPLY0, REPLY1.
REQ-018 In IDLE, when com_count >= 8, the FSM SHALL clear byte index idx to 0 and go to FETCH; it SHALL never start a frame with fewer than 8 bytes buffered.
REQ-019 In FETCH, the FSM SHALL latch rec_command into buf[idx], assert com_pop for exactly that cycle, and go to GAP.
REQ-020 In GAP, the FSM SHALL not pop (one-cycle FIFO head update); if idx = 7 it SHALL go to CHECK, else it SHALL increment idx and return to FETCH.
REQ-021 Header resync: if buf[0] != 0xEB after idx 0 is fetched, or buf[1] != 0x90 after idx 1 is fetched, the FSM SHALL return to IDLE with that byte discarded and without asserting error.
REQ-022 In CHECK, a checksum mismatch or a cmd outside {0x01..0x05} SHALL load the error timer to ERR_HOLD and return to IDLE with no reply; otherwise the FSM SHALL go to EXEC.
REQ-023 In EXEC, the FSM SHALL apply the command within one cycle:
  - 0x01: force_swi=1, com_swi=0.
  - 0x02: force_swi=1, com_swi=1.
  - 0x03: reset_A timer loaded to RST_PULSE.
  - 0x04: reset_B timer loaded to RST_PULSE.
  - 0x05: force_swi=0; com_swi unchanged.
REQ-024 The reply SHALL be 2 bytes: REPLY0 pushes 0xAC, REPLY1 pushes cmd, one push per cycle; the FSM SHALL then return to IDLE. Frame latency from first FETCH to the first reply push SHALL be 19 cycles.
REQ-025 reset_A/reset_B SHALL be high for exactly RST_PULSE cycles after the load; a reload while active SHALL restart the count.
REQ-026 error SHALL be high while the error timer is nonzero; a new error while active SHALL reload the timer to ERR_HOLD.
REQ-027 The timers SHALL saturate at 0 with no wrap; timer widths SHALL be clog2(parameter+1).
REQ-028 com_pop SHALL never be asserted in two consecutive cycles, and SHALL never be asserted when com_count = 0.

Reset
REQ-029 While rst_n = 0, the block SHALL hold state IDLE, idx=0, all buffers 0, all timers 0, and all outputs 0.
REQ-030 Deassertion of rst_n mid-frame SHALL not resume the frame; bytes already popped SHALL be lost.

Verification
REQ-031 Frame EB 90 02 00 00 00 00 7D with com_count=8 -> 8 pops on alternate cycles; force_swi=1 and com_swi=1; replies AC then 02.
REQ-032 Frame EB 90 03 00 00 00 00 7E -> reset_A high for exactly 16 cycles; reset_B stays 0; replies AC then 03.
REQ-033 Frame EB 90 01 00 00 00 00 00 (bad checksum) -> error high for 1024 cycles; no push; force_swi unchanged.
REQ-034 Stream 55 EB 90 05 00 00 00 00 80 -> 0x55 discarded silently; the following frame executes and force_swi=0.
REQ-035 com_count=7 held -> no pop, FSM stays in IDLE; raise com_count to 8 -> the frame starts on the next cycle.
REQ-036 rst_n asserted low after the 4th pop -> all outputs 0 immediately; after release, the FSM waits for com_count >= 8.
